// File: rtl/conv_frame_writer.sv
// conv_frame_writer: collects one filtered frame from the convolution stream
// and writes it to frame memory through a small elastic FIFO. Each accepted
// pixel carries its own output address, so dropped pixels never shift later
// addresses.
module conv_frame_writer #(
    parameter int WORD_SIZE  = 8,
    parameter int ROW_SIZE   = 540,
    parameter int NUM_ROWS   = 540,
    parameter int FIFO_DEPTH = 4,
    localparam int OUT_W     = ROW_SIZE - 2,
    localparam int OUT_H     = NUM_ROWS - 2,
    localparam int FRAME_PIX = OUT_W * OUT_H,
    localparam int AW        = $clog2(FRAME_PIX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] inPixel,
    input  logic [1:0]           inValid,
    input  logic                 wrReady,
    output logic                 wrEn,
    output logic [AW-1:0]        wrAddr,
    output logic [WORD_SIZE-1:0] wrData,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AW + WORD_SIZE;

    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_PIX - 1);
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   PTR_ONE  = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  push_cnt;
    logic [PW:0]    wr_ptr, rd_ptr;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [EW-1:0]  head;
    logic           empty, full, accept, push, pop, start_ok, last_pix;

    // Next-state, FIFO handshake and output decode; outputs are gated to zero when the FIFO is empty
    always_comb begin
        state_nxt = state;
        head      = mem[rd_ptr[PW-1:0]];
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        wrEn      = !empty;
        pop       = wrEn && wrReady;
        accept    = (state == COLLECT) && (inValid != 2'b00);
        // a full FIFO still takes the pixel when the head leaves on the same edge
        push      = accept && (!full || pop);
        start_ok  = (state == IDLE) && start;
        last_pix  = accept && (push_cnt == LAST_IDX);
        wrAddr    = '0;
        wrData    = '0;
        if (wrEn) begin
            wrAddr = head[EW-1:WORD_SIZE];
            wrData = head[WORD_SIZE-1:0];
        end
        busy = (state == COLLECT) || (state == DRAIN);
        done = (state == DONE);
        case (state)
            IDLE:    if (start_ok) state_nxt = COLLECT;
            COLLECT: if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (empty)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO payload storage: {address, pixel}; contents are never reset, only the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {push_cnt, inPixel};
    end

    // Control state: FSM, push counter, FIFO pointers and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            push_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                push_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                // the counter advances even on a drop so later addresses stay correct
                if (accept)          push_cnt <= push_cnt + CNT_ONE;
                if (push)            wr_ptr   <= wr_ptr + PTR_ONE;
                if (pop)             rd_ptr   <= rd_ptr + PTR_ONE;
                if (accept && !push) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Directed bench for conv_frame_writer with a 5x4 input image (6-pixel output
// frame) and a 4-entry FIFO.
module tb_conv_frame_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] inPixel;
    logic [1:0] inValid;
    logic       wrReady;
    logic       wrEn;
    logic [2:0] wrAddr;
    logic [7:0] wrData;
    logic       busy;
    logic       done;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [2:0] wa[$];
    logic [7:0] wd[$];

    conv_frame_writer #(
        .WORD_SIZE (8),
        .ROW_SIZE  (5),
        .NUM_ROWS  (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .inPixel (inPixel),
        .inValid (inValid),
        .wrReady (wrReady),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // log every completed write and every done pulse
    always @(posedge clk) begin
        if (wrEn === 1'b1 && wrReady === 1'b1) begin
            wa.push_back(wrAddr);
            wd.push_back(wrData);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_in_done"}, busy, 0);
        cyc();
        chk({tag, "_done_clear"}, done, 0);
    endtask

    // expected writes: addresses 0..5 except skip, data = base + address
    task automatic chk_writes(input string tag, input int base, input int skip);
        int k = 0;
        int n_exp = (skip >= 0) ? 5 : 6;
        chk({tag, "_count"}, wa.size(), n_exp);
        for (int a = 0; a < 6; a++) begin
            if (a != skip) begin
                if (k < wa.size()) begin
                    chk({tag, "_addr"}, wa[k], a);
                    chk({tag, "_data"}, wd[k], base + a);
                end
                k++;
            end
        end
        chk({tag, "_done_pulses"}, done_cnt, 1);
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; inPixel = 8'd0; inValid = 2'b00; wrReady = 1'b1;
        #1;
        chk("rst_wrEn", wrEn, 0);
        chk("rst_wrAddr", wrAddr, 0);
        chk("rst_wrData", wrData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        cyc();
        rst = 1'b1;
        cyc();

        // basic frame, full throughput
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            inPixel = 8'(10 + i); inValid = 2'b01;
            cyc();
            chk("t1_wrEn", wrEn, 1);
            chk("t1_lat_addr", wrAddr, i);
            chk("t1_lat_data", wrData, 10 + i);
        end
        inValid = 2'b00;
        wait_done("t1");
        chk("t1_overflow", overflow, 0);
        chk_writes("t1", 10, -1);

        // back-pressure: 5th pixel dropped, 6th pushed while head pops
        wrReady = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inPixel = 8'(20 + i); inValid = 2'b01; wrReady = (i == 5);
            cyc();
            if (i == 4) begin
                chk("t2_ovf_set", overflow, 1);
                chk("t2_hold_addr", wrAddr, 0);
                chk("t2_hold_data", wrData, 20);
            end
        end
        inValid = 2'b00;
        chk("t2_busy_drain", busy, 1);
        wait_done("t2");
        chk("t2_ovf_sticky", overflow, 1);
        chk_writes("t2", 20, 4);

        // early pixels ignored, second start ignored, all inValid encodings
        wrReady = 1'b1;
        inPixel = 8'd99; inValid = 2'b11;
        cyc();
        cyc();
        chk("t3_idle_wrEn", wrEn, 0);
        chk("t3_idle_ovf", overflow, 1);
        inValid = 2'b00;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t3_ovf_cleared", overflow, 0);
        for (int i = 0; i < 6; i++) begin
            inPixel = 8'(30 + i);
            inValid = (i % 3 == 0) ? 2'b10 : ((i % 3 == 1) ? 2'b11 : 2'b01);
            start = (i == 2);
            cyc();
            chk("t3_addr", wrAddr, i);
            chk("t3_data", wrData, 30 + i);
        end
        start = 1'b0; inValid = 2'b00;
        wait_done("t3");
        chk("t3_overflow", overflow, 0);
        chk_writes("t3", 30, -1);

        // asynchronous reset mid-frame discards buffered writes
        wrReady = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inPixel = 8'(40 + i); inValid = 2'b01;
            cyc();
        end
        inValid = 2'b00;
        chk("t4_pending", wrEn, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_async_wrEn", wrEn, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_addr", wrAddr, 0);
        chk("t4_async_data", wrData, 0);
        wrReady = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        chk("t4_no_writes", wa.size(), 0);
        chk("t4_idle_busy", busy, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inPixel = 8'(50 + i); inValid = 2'b01;
            cyc();
        end
        inValid = 2'b00;
        wait_done("t4");
        chk_writes("t4", 50, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
